// File: rtl/xmpl_sram_burst_master_pkg.sv
`default_nettype none
// ============================================================================
//  Package : xmpl_sram_pkg
//  Purpose : Shared types and constants for the SRAM burst master:
//            FSM state encoding, read/write encoding, response buffer depth,
//            SRAM read latency and default bus widths.
//  Revision: 1.0 - initial release
// ============================================================================
package xmpl_sram_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Response FIFO depth; also the read credit limit (buffered + in flight).
  localparam int RSP_DEPTH   = 4;
  // Cycles from the en_sram cycle to the cycle sram_data_i is valid.
  localparam int SRAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } mst_state_t;

endpackage
`default_nettype wire

// File: rtl/xmpl_sram_burst_master_if.sv
`default_nettype none
// ============================================================================
//  Interface : xmpl_sram_burst_master_if
//  Purpose   : Bundles the client-side command / write / read-response
//              streams, the status pulses and the SRAM pin-level signals.
//  Modports  : master - the burst master (drives ready/response/SRAM pins)
//              slave  - the client plus SRAM macro side
//  Revision  : 1.0 - initial release
// ============================================================================
interface xmpl_sram_burst_master_if #(
  parameter int ADDR_W = xmpl_sram_pkg::ADDR_W_DEF,
  parameter int DATA_W = xmpl_sram_pkg::DATA_W_DEF,
  parameter int LEN_W  = xmpl_sram_pkg::LEN_W_DEF
);

  // command stream
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_rw_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [LEN_W-1:0]  cmd_len_i;
  // write-data stream
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [DATA_W-1:0] wr_data_i;
  // read-response stream
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_last_o;
  // status
  logic              done_o;
  logic              err_o;
  logic              busy_o;
  // SRAM pins
  logic              en_sram_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic              sram_rw_o;
  logic [DATA_W-1:0] sram_data_o;
  logic [DATA_W-1:0] sram_data_i;

  modport master (
    input  cmd_valid_i, cmd_rw_i, cmd_addr_i, cmd_len_i,
    input  wr_valid_i, wr_data_i,
    input  rd_ready_i,
    input  sram_data_i,
    output cmd_ready_o, wr_ready_o,
    output rd_valid_o, rd_data_o, rd_last_o,
    output done_o, err_o, busy_o,
    output en_sram_o, sram_addr_o, sram_rw_o, sram_data_o
  );

  modport slave (
    output cmd_valid_i, cmd_rw_i, cmd_addr_i, cmd_len_i,
    output wr_valid_i, wr_data_i,
    output rd_ready_i,
    output sram_data_i,
    input  cmd_ready_o, wr_ready_o,
    input  rd_valid_o, rd_data_o, rd_last_o,
    input  done_o, err_o, busy_o,
    input  en_sram_o, sram_addr_o, sram_rw_o, sram_data_o
  );

endinterface
`default_nettype wire

// File: rtl/xmpl_sram_burst_master_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : xmpl_sram_rsp_fifo
//  Purpose : RSP_DEPTH-entry synchronous FIFO holding {last, data} read beats
//            between the SRAM capture point and the response stream.
//  Ports   : clk_i, reset_i (async, active-high)
//            push_i/push_last_i/push_data_i - write side
//            pop_i                          - read side (ignored when empty)
//            valid_o/data_o/last_o          - head entry, zero when empty
//            count_o                        - number of stored entries
//  Revision: 1.0 - initial release
// ============================================================================
module xmpl_sram_rsp_fifo
  import xmpl_sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            push_i,
  input  logic                            push_last_i,
  input  logic [DATA_W-1:0]               push_data_i,
  input  logic                            pop_i,
  output logic                            valid_o,
  output logic [DATA_W-1:0]               data_o,
  output logic                            last_o,
  output logic [$clog2(RSP_DEPTH):0]      count_o
);

  localparam int PTR_W = $clog2(RSP_DEPTH);

  logic [DATA_W:0]  mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count != (PTR_W+1)'(RSP_DEPTH));
  assign do_pop  = pop_i  && (count != '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_last_i, push_data_i};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign valid_o = (count != '0);
  assign data_o  = valid_o ? mem[rd_ptr][DATA_W-1:0] : '0;
  assign last_o  = valid_o & mem[rd_ptr][DATA_W];
  assign count_o = count;

endmodule
`default_nettype wire

// File: rtl/xmpl_sram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module  : xmpl_sram_burst_master
//  Purpose : Burst initiator for a single-port SRAM. Accepts read/write burst
//            commands, streams write beats to the SRAM and returns read beats
//            through a credit-limited response FIFO.
//  Ports   : clk_i   - clock, rising edge
//            reset_i - asynchronous active-high reset
//            bus     - xmpl_sram_burst_master_if.master (command, write data,
//                      read response, status pulses, SRAM pins)
//  Options : XMPL_SRAM_MST_BOUNDARY_CHK_EN - when defined, commands whose
//            last address passes 2^ADDR_W-1 are accepted but not executed and
//            err_o/done_o pulse together; otherwise addresses wrap and err_o
//            is held at 0.
//  Revision: 1.0 - initial release
// ============================================================================
module xmpl_sram_burst_master
  import xmpl_sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  xmpl_sram_burst_master_if.master bus
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  // control state
  mst_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LEN_W-1:0]  cnt_q, cnt_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic              rw_q, rw_nxt;
  logic              err_q, err_nxt;

  // beat decided this cycle, presented on the SRAM pins next cycle
  logic              issue;
  logic              issue_last;
  logic              issue_rw;
  logic [ADDR_W-1:0] issue_addr;

  // registered SRAM pins
  logic              en_q;
  logic              en_last_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic              sram_rw_q;
  logic [DATA_W-1:0] sram_data_q;

  // read capture pipeline: one bit per cycle between en and data valid
  logic [SRAM_RD_LAT-1:0] pipe_vld;
  logic [SRAM_RD_LAT-1:0] pipe_last;

  // handshakes / status
  logic cmd_ready;
  logic wr_ready;
  logic done;
  logic bound_err;
  logic credit;
  logic en_rd;

  // response FIFO
  logic              fifo_valid;
  logic              fifo_last;
  logic [DATA_W-1:0] fifo_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic [CNT_W:0]    inflight;

`ifdef XMPL_SRAM_MST_BOUNDARY_CHK_EN
  // One extra bit catches any burst whose last beat passes the top address.
  logic [ADDR_W:0] end_addr;
  assign end_addr  = {1'b0, bus.cmd_addr_i} + (ADDR_W+1)'(bus.cmd_len_i);
  assign bound_err = end_addr[ADDR_W];
`else
  assign bound_err = 1'b0;
`endif

  // Credit covers FIFO entries plus beats still on their way from the SRAM,
  // so a beat is only issued when a FIFO slot is guaranteed for it.
  assign en_rd    = en_q && (sram_rw_q == RW_READ);
  assign inflight = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(en_rd)
                  + (CNT_W+1)'($countones(pipe_vld));
  assign credit   = inflight < (CNT_W+1)'(RSP_DEPTH);
  assign pop      = fifo_valid && bus.rd_ready_i;

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    cnt_nxt    = cnt_q;
    len_nxt    = len_q;
    rw_nxt     = rw_q;
    err_nxt    = err_q;
    issue      = 1'b0;
    issue_addr = addr_q;
    issue_rw   = rw_q;
    issue_last = (cnt_q == len_q);
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;

    case (state)
      ST_IDLE: begin
        // The first beat is issued in the acceptance cycle so that the SRAM
        // sees it one cycle later; a write needs its data in that cycle too.
        cmd_ready  = 1'b1;
        issue_addr = bus.cmd_addr_i;
        issue_rw   = bus.cmd_rw_i;
        issue_last = (bus.cmd_len_i == '0);
        wr_ready   = bus.cmd_valid_i && (bus.cmd_rw_i == RW_WRITE) && !bound_err;
        if (bus.cmd_valid_i) begin
          len_nxt  = bus.cmd_len_i;
          rw_nxt   = bus.cmd_rw_i;
          err_nxt  = bound_err;
          addr_nxt = bus.cmd_addr_i;
          cnt_nxt  = '0;
          if (bound_err) begin
            state_nxt = ST_DRAIN;
          end else begin
            issue = (bus.cmd_rw_i == RW_WRITE) ? bus.wr_valid_i : credit;
            if (issue) begin
              addr_nxt = bus.cmd_addr_i + ADDR_W'(1);
              cnt_nxt  = LEN_W'(1);
            end
            if (issue && issue_last) begin
              state_nxt = ST_DRAIN;
            end else begin
              state_nxt = (bus.cmd_rw_i == RW_WRITE) ? ST_WRITE : ST_READ;
            end
          end
        end
      end

      ST_WRITE, ST_READ: begin
        wr_ready = (state == ST_WRITE);
        issue    = (state == ST_WRITE) ? bus.wr_valid_i : credit;
        if (issue) begin
          addr_nxt = addr_q + ADDR_W'(1);
          cnt_nxt  = cnt_q + LEN_W'(1);
          if (issue_last) begin
            state_nxt = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Writes and rejected commands complete here in one cycle; reads
        // complete when the final beat leaves the FIFO.
        if ((rw_q == RW_WRITE) || err_q) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (pop && fifo_last) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      rw_q        <= RW_READ;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
      en_last_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_rw_q   <= RW_READ;
      sram_data_q <= '0;
      pipe_vld    <= '0;
      pipe_last   <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      cnt_q  <= cnt_nxt;
      len_q  <= len_nxt;
      rw_q   <= rw_nxt;
      err_q  <= err_nxt;
      en_q   <= issue;
      if (issue) begin
        sram_addr_q <= issue_addr;
        sram_rw_q   <= issue_rw;
        en_last_q   <= issue_last;
        if (issue_rw == RW_WRITE) begin
          sram_data_q <= bus.wr_data_i;
        end
      end
      pipe_vld[0]  <= en_rd;
      pipe_last[0] <= en_last_q;
      for (int i = 1; i < SRAM_RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  xmpl_sram_rsp_fifo #(
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (pipe_vld[SRAM_RD_LAT-1]),
    .push_last_i (pipe_last[SRAM_RD_LAT-1]),
    .push_data_i (bus.sram_data_i),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .last_o      (fifo_last),
    .count_o     (fifo_count)
  );

  // Ready outputs are combinational from state; gate them so they read 0
  // for the whole time reset is held.
  assign bus.cmd_ready_o = cmd_ready && !reset_i;
  assign bus.wr_ready_o  = wr_ready && !reset_i;
  assign bus.rd_valid_o  = fifo_valid;
  assign bus.rd_data_o   = fifo_data;
  assign bus.rd_last_o   = fifo_last;
  assign bus.done_o      = done;
  assign bus.busy_o      = (state != ST_IDLE);
  assign bus.en_sram_o   = en_q;
  assign bus.sram_addr_o = sram_addr_q;
  assign bus.sram_rw_o   = sram_rw_q;
  assign bus.sram_data_o = sram_data_q;

`ifdef XMPL_SRAM_MST_BOUNDARY_CHK_EN
  assign bus.err_o = done && err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xmpl_sram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module  : tb_xmpl_sram_burst_master
//  Purpose : Directed self-checking bench for xmpl_sram_burst_master with a
//            behavioural SRAM model (one-cycle read latency).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_xmpl_sram_burst_master;

  logic clk;
  logic reset_i;
  int   checks = 0;
  int   errors = 0;

  xmpl_sram_burst_master_if #(.ADDR_W(12), .DATA_W(32), .LEN_W(4)) bus ();

  xmpl_sram_burst_master #(.ADDR_W(12), .DATA_W(32), .LEN_W(4)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: writes land at the end of the en cycle, read data is
  // presented during the following cycle.
  logic [31:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | i;
  end
  always @(posedge clk) begin
    if (bus.en_sram_o) begin
      if (bus.sram_rw_o) mem[bus.sram_addr_o] = bus.sram_data_o;
      else               bus.sram_data_i <= mem[bus.sram_addr_o];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [11:0] wrap_addr [4];
  int popped;
  int issued;
  int maxinf;
  bit seen_done;

  initial begin
    wrap_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    reset_i = 1'b1;
    bus.cmd_valid_i = 1'b0; bus.cmd_rw_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_len_i = '0;
    bus.wr_valid_i = 1'b0; bus.wr_data_i = '0; bus.rd_ready_i = 1'b0;

    // ---------------- reset state
    repeat (2) @(posedge clk);
    sample();
    chk1("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
    chk1("rst_wr_ready", bus.wr_ready_o, 1'b0);
    chk1("rst_en", bus.en_sram_o, 1'b0);
    chk1("rst_busy", bus.busy_o, 1'b0);
    chk1("rst_rd_valid", bus.rd_valid_o, 1'b0);
    chk1("rst_done", bus.done_o, 1'b0);
    chk1("rst_err", bus.err_o, 1'b0);
    drive_edge(); reset_i = 1'b0;
    sample();
    chk1("idle_cmd_ready", bus.cmd_ready_o, 1'b1);

    // ---------------- write burst 0x010, 4 beats, wr_valid held
    drive_edge();
    bus.cmd_valid_i = 1'b1; bus.cmd_rw_i = 1'b1; bus.cmd_addr_i = 12'h010; bus.cmd_len_i = 4'd3;
    bus.wr_valid_i = 1'b1; bus.wr_data_i = 32'hA0;
    sample();
    chk1("wr_c0_cmd_ready", bus.cmd_ready_o, 1'b1);
    chk1("wr_c0_wr_ready", bus.wr_ready_o, 1'b1);
    chk1("wr_c0_en", bus.en_sram_o, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      drive_edge();
      bus.cmd_valid_i = 1'b0;
      if (k < 4) bus.wr_data_i = 32'hA0 + k;
      else       bus.wr_valid_i = 1'b0;
      sample();
      chk1("wr_en", bus.en_sram_o, 1'b1);
      chk32("wr_addr", 32'(bus.sram_addr_o), 32'h10 + k - 1);
      chk1("wr_rw", bus.sram_rw_o, 1'b1);
      chk32("wr_data", bus.sram_data_o, 32'hA0 + k - 1);
      chk1("wr_done", bus.done_o, k == 4);
      chk1("wr_cmd_ready_busy", bus.cmd_ready_o, 1'b0);
    end
    drive_edge(); sample();
    chk1("wr_end_en", bus.en_sram_o, 1'b0);
    chk1("wr_end_cmd_ready", bus.cmd_ready_o, 1'b1);
    chk1("wr_end_busy", bus.busy_o, 1'b0);

    // ---------------- read back 0x010, 4 beats, rd_ready held
    drive_edge();
    bus.cmd_valid_i = 1'b1; bus.cmd_rw_i = 1'b0; bus.cmd_addr_i = 12'h010; bus.cmd_len_i = 4'd3;
    bus.rd_ready_i = 1'b1;
    sample();
    chk1("rd_c0_cmd_ready", bus.cmd_ready_o, 1'b1);
    drive_edge(); bus.cmd_valid_i = 1'b0;
    sample();
    chk1("rd_c1_en", bus.en_sram_o, 1'b1);
    chk32("rd_c1_addr", 32'(bus.sram_addr_o), 32'h010);
    chk1("rd_c1_rw", bus.sram_rw_o, 1'b0);
    chk1("rd_c1_valid", bus.rd_valid_o, 1'b0);
    drive_edge(); sample();
    chk1("rd_c2_valid", bus.rd_valid_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_edge(); sample();
      chk1("rd_valid", bus.rd_valid_o, 1'b1);
      chk32("rd_data", bus.rd_data_o, 32'hA0 + k);
      chk1("rd_last", bus.rd_last_o, k == 3);
      chk1("rd_done", bus.done_o, k == 3);
    end
    drive_edge(); sample();
    chk1("rd_end_valid", bus.rd_valid_o, 1'b0);
    chk1("rd_end_cmd_ready", bus.cmd_ready_o, 1'b1);

    // ---------------- 16-beat read 0x100 with rd_ready toggling
    drive_edge();
    bus.cmd_valid_i = 1'b1; bus.cmd_rw_i = 1'b0; bus.cmd_addr_i = 12'h100; bus.cmd_len_i = 4'd15;
    bus.rd_ready_i = 1'b0;
    sample();
    popped = 0; issued = 0; maxinf = 0; seen_done = 1'b0;
    for (int c = 1; c < 200 && !seen_done; c++) begin
      drive_edge();
      bus.cmd_valid_i = 1'b0;
      bus.rd_ready_i = (c % 2) == 1;
      sample();
      if (bus.en_sram_o && !bus.sram_rw_o) issued++;
      if (issued - popped > maxinf) maxinf = issued - popped;
      if (bus.rd_valid_o && bus.rd_ready_i) begin
        chk32("rd16_data", bus.rd_data_o, 32'h5A00_0100 + popped);
        chk1("rd16_last", bus.rd_last_o, popped == 15);
        chk1("rd16_done", bus.done_o, popped == 15);
        if (bus.done_o) seen_done = 1'b1;
        popped++;
      end
    end
    chk32("rd16_count", 32'(popped), 32'd16);
    chk1("rd16_max_inflight", maxinf <= 4, 1'b1);
    bus.rd_ready_i = 1'b1;
    drive_edge(); sample();
    chk1("rd16_end_valid", bus.rd_valid_o, 1'b0);

    // ---------------- address wrap 0xFFE, 4 beats
    drive_edge();
    bus.cmd_valid_i = 1'b1; bus.cmd_rw_i = 1'b1; bus.cmd_addr_i = 12'hFFE; bus.cmd_len_i = 4'd3;
    bus.wr_valid_i = 1'b1; bus.wr_data_i = 32'hD0;
    sample();
`ifdef XMPL_SRAM_MST_BOUNDARY_CHK_EN
    chk1("bnd_c0_wr_ready", bus.wr_ready_o, 1'b0);
    drive_edge(); bus.cmd_valid_i = 1'b0; bus.wr_valid_i = 1'b0;
    sample();
    chk1("bnd_c1_err", bus.err_o, 1'b1);
    chk1("bnd_c1_done", bus.done_o, 1'b1);
    chk1("bnd_c1_en", bus.en_sram_o, 1'b0);
    drive_edge(); sample();
    chk1("bnd_c2_en", bus.en_sram_o, 1'b0);
    chk1("bnd_c2_err", bus.err_o, 1'b0);
    chk1("bnd_c2_cmd_ready", bus.cmd_ready_o, 1'b1);
`else
    for (int k = 1; k <= 4; k++) begin
      drive_edge();
      bus.cmd_valid_i = 1'b0;
      if (k < 4) bus.wr_data_i = 32'hD0 + k;
      else       bus.wr_valid_i = 1'b0;
      sample();
      chk1("wrap_en", bus.en_sram_o, 1'b1);
      chk32("wrap_addr", 32'(bus.sram_addr_o), 32'(wrap_addr[k-1]));
      chk1("wrap_done", bus.done_o, k == 4);
      chk1("wrap_err", bus.err_o, 1'b0);
    end
    drive_edge(); sample();
    chk1("wrap_end_en", bus.en_sram_o, 1'b0);
`endif

    // ---------------- write with gaps, 0x020, 2 beats
    drive_edge();
    bus.cmd_valid_i = 1'b1; bus.cmd_rw_i = 1'b1; bus.cmd_addr_i = 12'h020; bus.cmd_len_i = 4'd1;
    bus.wr_valid_i = 1'b1; bus.wr_data_i = 32'hB0;
    sample();
    chk1("gap_c0_en", bus.en_sram_o, 1'b0);
    drive_edge(); bus.cmd_valid_i = 1'b0; bus.wr_valid_i = 1'b0;
    sample();
    chk1("gap_c1_en", bus.en_sram_o, 1'b1);
    chk32("gap_c1_data", bus.sram_data_o, 32'hB0);
    drive_edge(); sample();
    chk1("gap_c2_en", bus.en_sram_o, 1'b0);
    drive_edge(); bus.wr_valid_i = 1'b1; bus.wr_data_i = 32'hB1;
    sample();
    chk1("gap_c3_en", bus.en_sram_o, 1'b0);
    chk1("gap_c3_wr_ready", bus.wr_ready_o, 1'b1);
    drive_edge(); bus.wr_valid_i = 1'b0;
    sample();
    chk1("gap_c4_en", bus.en_sram_o, 1'b1);
    chk32("gap_c4_addr", 32'(bus.sram_addr_o), 32'h021);
    chk32("gap_c4_data", bus.sram_data_o, 32'hB1);
    chk1("gap_c4_done", bus.done_o, 1'b1);
    drive_edge(); sample();
    chk1("gap_c5_en", bus.en_sram_o, 1'b0);

    // ---------------- reset in cycle 2 of an 8-beat read
    drive_edge();
    bus.cmd_valid_i = 1'b1; bus.cmd_rw_i = 1'b0; bus.cmd_addr_i = 12'h100; bus.cmd_len_i = 4'd7;
    bus.rd_ready_i = 1'b1;
    drive_edge(); bus.cmd_valid_i = 1'b0;
    drive_edge();
    #2 reset_i = 1'b1;
    #1;
    chk1("arst_en", bus.en_sram_o, 1'b0);
    chk1("arst_busy", bus.busy_o, 1'b0);
    chk1("arst_cmd_ready", bus.cmd_ready_o, 1'b0);
    chk1("arst_rd_valid", bus.rd_valid_o, 1'b0);
    chk32("arst_addr", 32'(bus.sram_addr_o), 32'h0);
    drive_edge(); reset_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk1("arst_after_valid", bus.rd_valid_o, 1'b0);
      chk1("arst_after_done", bus.done_o, 1'b0);
      drive_edge();
    end
    bus.cmd_valid_i = 1'b1; bus.cmd_rw_i = 1'b0; bus.cmd_addr_i = 12'h010; bus.cmd_len_i = 4'd0;
    sample();
    chk1("post_c0_cmd_ready", bus.cmd_ready_o, 1'b1);
    drive_edge(); bus.cmd_valid_i = 1'b0;
    sample();
    chk1("post_c1_en", bus.en_sram_o, 1'b1);
    chk32("post_c1_addr", 32'(bus.sram_addr_o), 32'h010);
    drive_edge(); sample();
    chk1("post_c2_valid", bus.rd_valid_o, 1'b0);
    drive_edge(); sample();
    chk1("post_c3_valid", bus.rd_valid_o, 1'b1);
    chk32("post_c3_data", bus.rd_data_o, 32'hA0);
    chk1("post_c3_last", bus.rd_last_o, 1'b1);
    chk1("post_c3_done", bus.done_o, 1'b1);
    drive_edge(); sample();
    chk1("post_c4_busy", bus.busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
